// File: rtl/gpr_file_dbg_if.sv
// Debug access channel of the GPR file: valid/ready request and valid/ready response.
// The debugger/simulator side uses the master modport, the register file the slave modport.
interface gpr_file_dbg_if #(
    parameter int unsigned XLEN = 64
);
    logic            dbg_req_valid;
    logic            dbg_req_ready;
    logic            dbg_req_write;
    logic [4:0]      dbg_req_addr;
    logic [XLEN-1:0] dbg_req_wdata;
    logic            dbg_resp_valid;
    logic            dbg_resp_ready;
    logic [XLEN-1:0] dbg_resp_rdata;
    logic            dbg_resp_err;

    modport master (
        output dbg_req_valid,
        input  dbg_req_ready,
        output dbg_req_write,
        output dbg_req_addr,
        output dbg_req_wdata,
        input  dbg_resp_valid,
        output dbg_resp_ready,
        input  dbg_resp_rdata,
        input  dbg_resp_err
    );

    modport slave (
        input  dbg_req_valid,
        output dbg_req_ready,
        input  dbg_req_write,
        input  dbg_req_addr,
        input  dbg_req_wdata,
        output dbg_resp_valid,
        input  dbg_resp_ready,
        output dbg_resp_rdata,
        output dbg_resp_err
    );
endinterface

// File: rtl/gpr_file_dbg.sv
// 32 x XLEN architectural register file with two core read ports, one write-back port,
// a debugger read/overwrite port and a flat export of all register contents.
module gpr_file_dbg #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [4:0]         raddr1,
    output logic [XLEN-1:0]    rdata1,
    input  logic [4:0]         raddr2,
    output logic [XLEN-1:0]    rdata2,
    input  logic               wen,
    input  logic [4:0]         waddr,
    input  logic [XLEN-1:0]    wdata,
    input  logic               halted,
    gpr_file_dbg_if.slave      dbg,
    output logic [32*XLEN-1:0] rf_flat
);
    localparam int unsigned CW = 10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] regs_q [32];

    logic            lat_write_q, lat_write_d;
    logic [4:0]      lat_addr_q,  lat_addr_d;
    logic [XLEN-1:0] lat_wdata_q, lat_wdata_d;
    logic [CW-1:0]   cnt_q,       cnt_d;
    logic            resp_valid_q, resp_valid_d;
    logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
    logic            resp_err_q,   resp_err_d;

    logic            slot_free;
    logic            dbg_access;
    logic            req_ready;
    logic            dbg_we;
    logic            core_we;

    assign rdata1 = (raddr1 == 5'd0) ? '0 : regs_q[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? '0 : regs_q[raddr2];

    assign slot_free = halted || !wen;

    always_comb begin
        state_d      = state_q;
        lat_write_d  = lat_write_q;
        lat_addr_d   = lat_addr_q;
        lat_wdata_d  = lat_wdata_q;
        cnt_d        = cnt_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        dbg_access   = 1'b0;
        req_ready    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (dbg.dbg_req_valid) begin
                    lat_write_d = dbg.dbg_req_write;
                    lat_addr_d  = dbg.dbg_req_addr;
                    lat_wdata_d = dbg.dbg_req_wdata;
                    cnt_d       = '0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (slot_free) begin
                    dbg_access   = 1'b1;
                    resp_rdata_d = (lat_write_q || lat_addr_q == 5'd0) ? '0 : regs_q[lat_addr_q];
                    resp_err_d   = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    // The TIMEOUT-th busy cycle gives up without touching the registers.
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b1;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                if (dbg.dbg_resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            lat_write_q  <= 1'b0;
            lat_addr_q   <= '0;
            lat_wdata_q  <= '0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_write_q  <= lat_write_d;
            lat_addr_q   <= lat_addr_d;
            lat_wdata_q  <= lat_wdata_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // A debug write slot owns the write port for that cycle; a concurrent core write is dropped.
    assign dbg_we  = dbg_access && lat_write_q && (lat_addr_q != 5'd0);
    assign core_we = wen && (waddr != 5'd0) && !(dbg_access && lat_write_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (dbg_we) begin
            regs_q[lat_addr_q] <= lat_wdata_q;
        end else if (core_we) begin
            regs_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rf_flat = '0;
        for (int unsigned i = 1; i < 32; i++) begin
            rf_flat[i*XLEN +: XLEN] = regs_q[i];
        end
    end

    assign dbg.dbg_req_ready  = req_ready;
    assign dbg.dbg_resp_valid = resp_valid_q;
    assign dbg.dbg_resp_rdata = resp_rdata_q;
    assign dbg.dbg_resp_err   = resp_err_q;
endmodule

// File: tb/tb_gpr_file_dbg.sv
// Directed bench for gpr_file_dbg: vector table of debug accesses plus hand-written
// sequences for write-slot waiting, timeout, response back-pressure and reset mid-access.
module tb_gpr_file_dbg;
    localparam int unsigned XLEN = 64;

    logic               clock = 1'b0;
    logic               reset;
    logic [4:0]         raddr1, raddr2, waddr;
    logic [XLEN-1:0]    rdata1, rdata2, wdata;
    logic               wen, halted;
    logic [32*XLEN-1:0] rf_flat;

    gpr_file_dbg_if #(.XLEN(XLEN)) dbg_if ();

    gpr_file_dbg #(.XLEN(XLEN), .TIMEOUT(4)) dut (
        .clock   (clock),
        .reset   (reset),
        .raddr1  (raddr1),
        .rdata1  (rdata1),
        .raddr2  (raddr2),
        .rdata2  (rdata2),
        .wen     (wen),
        .waddr   (waddr),
        .wdata   (wdata),
        .halted  (halted),
        .dbg     (dbg_if.slave),
        .rf_flat (rf_flat)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic            wr;
        logic [4:0]      addr;
        logic [XLEN-1:0] wdata;
        logic [XLEN-1:0] exp_rdata;
        logic            exp_err;
    } vec_t;

    vec_t vecs [10];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] rf_reg(input int unsigned idx);
        return rf_flat[idx*XLEN +: XLEN];
    endfunction

    // One complete debug access; lat counts negedges after acceptance until resp_valid.
    task automatic dbg_op(input logic wr, input logic [4:0] a, input logic [63:0] d,
                          output logic [63:0] rd, output logic er, output int lat);
        @(negedge clock);
        dbg_if.dbg_req_valid = 1'b1;
        dbg_if.dbg_req_write = wr;
        dbg_if.dbg_req_addr  = a;
        dbg_if.dbg_req_wdata = d;
        chk("req_ready_idle", {63'd0, dbg_if.dbg_req_ready}, 64'd1);
        @(negedge clock);
        dbg_if.dbg_req_valid = 1'b0;
        lat = 0;
        while (!dbg_if.dbg_resp_valid && lat < 30) begin
            @(negedge clock);
            lat++;
        end
        chk("resp_arrived", {63'd0, dbg_if.dbg_resp_valid}, 64'd1);
        rd = dbg_if.dbg_resp_rdata;
        er = dbg_if.dbg_resp_err;
        dbg_if.dbg_resp_ready = 1'b1;
        @(negedge clock);
        dbg_if.dbg_resp_ready = 1'b0;
        chk("resp_dropped", {63'd0, dbg_if.dbg_resp_valid}, 64'd0);
    endtask

    task automatic core_write(input logic [4:0] a, input logic [63:0] d);
        @(negedge clock);
        wen = 1'b1; waddr = a; wdata = d;
        @(negedge clock);
        wen = 1'b0;
    endtask

    initial begin
        logic [63:0] rd;
        logic        er;
        int          lat;

        vecs[0] = '{1'b1, 5'd3,  64'h0123_4567_89AB_CDEF, 64'h0, 1'b0};
        vecs[1] = '{1'b0, 5'd3,  64'h0,                   64'h0123_4567_89AB_CDEF, 1'b0};
        vecs[2] = '{1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0};
        vecs[3] = '{1'b0, 5'd31, 64'h0,                   64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[4] = '{1'b1, 5'd0,  64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0};
        vecs[5] = '{1'b0, 5'd0,  64'h0,                   64'h0, 1'b0};
        vecs[6] = '{1'b0, 5'd5,  64'h0,                   64'h1234_5678_9ABC_DEF0, 1'b0};
        vecs[7] = '{1'b1, 5'd3,  64'h5A5A_A5A5_0F0F_F0F0, 64'h0, 1'b0};
        vecs[8] = '{1'b0, 5'd3,  64'h0,                   64'h5A5A_A5A5_0F0F_F0F0, 1'b0};
        vecs[9] = '{1'b0, 5'd31, 64'h0,                   64'hFFFF_FFFF_FFFF_FFFF, 1'b0};

        reset = 1'b1; raddr1 = '0; raddr2 = '0; waddr = '0; wdata = '0; wen = 1'b0; halted = 1'b0;
        dbg_if.dbg_req_valid = 1'b0; dbg_if.dbg_req_write = 1'b0; dbg_if.dbg_req_addr = '0;
        dbg_if.dbg_req_wdata = '0;   dbg_if.dbg_resp_ready = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        chk("reset_resp_valid", {63'd0, dbg_if.dbg_resp_valid}, 64'd0);
        chk("reset_resp_rdata", dbg_if.dbg_resp_rdata, 64'd0);
        chk("reset_resp_err",   {63'd0, dbg_if.dbg_resp_err}, 64'd0);
        chk("reset_rf_zero",    {63'd0, rf_flat == '0}, 64'd1);

        for (int unsigned i = 0; i < 32; i++) begin
            dbg_op(1'b0, 5'(i), 64'h0, rd, er, lat);
            chk("reset_dbg_read", rd, 64'h0);
            chk("reset_dbg_err", {63'd0, er}, 64'd0);
        end

        // Core write to x5 with no write-to-read bypass.
        @(negedge clock);
        wen = 1'b1; waddr = 5'd5; wdata = 64'h1234_5678_9ABC_DEF0; raddr1 = 5'd5;
        chk("no_bypass", rdata1, 64'h0);
        @(negedge clock);
        wen = 1'b0;
        chk("core_read_x5", rdata1, 64'h1234_5678_9ABC_DEF0);
        chk("rf_flat_x5", rf_reg(5), 64'h1234_5678_9ABC_DEF0);
        dbg_op(1'b0, 5'd5, 64'h0, rd, er, lat);
        chk("dbg_read_x5", rd, 64'h1234_5678_9ABC_DEF0);
        chk("dbg_read_x5_lat", 64'(lat), 64'd1);

        for (int unsigned i = 0; i < 10; i++) begin
            dbg_op(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            chk("vec_rdata", rd, vecs[i].exp_rdata);
            chk("vec_err", {63'd0, er}, {63'd0, vecs[i].exp_err});
            chk("vec_lat", 64'(lat), 64'd1);
        end

        raddr1 = 5'd0; raddr2 = 5'd31;
        @(negedge clock);
        chk("x0_rdata1", rdata1, 64'h0);
        chk("x0_rf_flat", rf_reg(0), 64'h0);
        chk("x31_rdata2", rdata2, 64'hFFFF_FFFF_FFFF_FFFF);

        // Debug write waits through three busy cycles, lands on the fourth WAIT cycle.
        @(negedge clock);
        wen = 1'b1; waddr = 5'd7; wdata = 64'h77; halted = 1'b0;
        dbg_if.dbg_req_valid = 1'b1; dbg_if.dbg_req_write = 1'b1;
        dbg_if.dbg_req_addr = 5'd10; dbg_if.dbg_req_wdata = 64'hAA;
        @(negedge clock);
        dbg_if.dbg_req_valid = 1'b0;
        repeat (2) @(negedge clock);
        chk("busy_ready_low", {63'd0, dbg_if.dbg_req_ready}, 64'd0);
        @(negedge clock);
        wen = 1'b0;
        chk("busy_no_resp", {63'd0, dbg_if.dbg_resp_valid}, 64'd0);
        chk("busy_x10_unwritten", rf_reg(10), 64'h0);
        @(negedge clock);
        chk("busy_resp_valid", {63'd0, dbg_if.dbg_resp_valid}, 64'd1);
        chk("busy_resp_err", {63'd0, dbg_if.dbg_resp_err}, 64'd0);
        chk("busy_resp_rdata", dbg_if.dbg_resp_rdata, 64'h0);
        chk("busy_x10", rf_reg(10), 64'hAA);
        chk("busy_x7_core", rf_reg(7), 64'h77);
        dbg_if.dbg_resp_ready = 1'b1;
        @(negedge clock);
        dbg_if.dbg_resp_ready = 1'b0;

        // Collision while halted: the debug write wins.
        halted = 1'b1;
        @(negedge clock);
        wen = 1'b1; waddr = 5'd12; wdata = 64'h55;
        dbg_if.dbg_req_valid = 1'b1; dbg_if.dbg_req_write = 1'b1;
        dbg_if.dbg_req_addr = 5'd12; dbg_if.dbg_req_wdata = 64'h99;
        @(negedge clock);
        dbg_if.dbg_req_valid = 1'b0;
        chk("collide_core_first", rf_reg(12), 64'h55);
        @(negedge clock);
        wen = 1'b0;
        chk("collide_resp_valid", {63'd0, dbg_if.dbg_resp_valid}, 64'd1);
        chk("collide_dbg_wins", rf_reg(12), 64'h99);
        dbg_if.dbg_resp_ready = 1'b1;
        @(negedge clock);
        dbg_if.dbg_resp_ready = 1'b0;
        halted = 1'b0;

        // Timeout: write slot never free.
        @(negedge clock);
        wen = 1'b1; waddr = 5'd7; wdata = 64'h7777;
        dbg_op(1'b1, 5'd20, 64'hDEAD, rd, er, lat);
        chk("tmo_wr_err", {63'd0, er}, 64'd1);
        chk("tmo_wr_rdata", rd, 64'h0);
        chk("tmo_wr_lat", 64'(lat), 64'd4);
        chk("tmo_x20_unchanged", rf_reg(20), 64'h0);
        dbg_op(1'b0, 5'd5, 64'h0, rd, er, lat);
        chk("tmo_rd_err", {63'd0, er}, 64'd1);
        chk("tmo_rd_rdata", rd, 64'h0);
        wen = 1'b0;

        // Response back-pressure for 5 cycles.
        @(negedge clock);
        dbg_if.dbg_req_valid = 1'b1; dbg_if.dbg_req_write = 1'b0; dbg_if.dbg_req_addr = 5'd5;
        @(negedge clock);
        dbg_if.dbg_req_valid = 1'b0;
        @(negedge clock);
        for (int unsigned i = 0; i < 5; i++) begin
            chk("hold_valid", {63'd0, dbg_if.dbg_resp_valid}, 64'd1);
            chk("hold_rdata", dbg_if.dbg_resp_rdata, 64'h1234_5678_9ABC_DEF0);
            chk("hold_err", {63'd0, dbg_if.dbg_resp_err}, 64'd0);
            chk("hold_req_ready", {63'd0, dbg_if.dbg_req_ready}, 64'd0);
            @(negedge clock);
        end
        dbg_if.dbg_resp_ready = 1'b1;
        @(negedge clock);
        dbg_if.dbg_resp_ready = 1'b0;
        chk("hold_released", {63'd0, dbg_if.dbg_resp_valid}, 64'd0);
        chk("hold_idle_ready", {63'd0, dbg_if.dbg_req_ready}, 64'd1);

        // Reset while waiting for a write slot.
        @(negedge clock);
        wen = 1'b1; waddr = 5'd9; wdata = 64'h9;
        dbg_if.dbg_req_valid = 1'b1; dbg_if.dbg_req_write = 1'b1;
        dbg_if.dbg_req_addr = 5'd21; dbg_if.dbg_req_wdata = 64'h1;
        @(negedge clock);
        dbg_if.dbg_req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1; wen = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        chk("rst_wait_no_resp", {63'd0, dbg_if.dbg_resp_valid}, 64'd0);
        chk("rst_wait_idle", {63'd0, dbg_if.dbg_req_ready}, 64'd1);
        chk("rst_wait_rf_zero", {63'd0, rf_flat == '0}, 64'd1);
        repeat (3) @(negedge clock);
        chk("rst_wait_still_no_resp", {63'd0, dbg_if.dbg_resp_valid}, 64'd0);
        chk("rst_wait_x21", rf_reg(21), 64'h0);
        dbg_op(1'b0, 5'd5, 64'h0, rd, er, lat);
        chk("rst_wait_x5_cleared", rd, 64'h0);
        chk("rst_wait_lat", 64'(lat), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/gpr_file_dbg.md
Name: gpr_file_dbg

Overview:
- Architectural 32x64 general-purpose register file for the core.
- Serves the core's two combinational read ports and one write-back port.
- Adds a simulator/debugger access port (valid/ready request, valid/ready response) so the C side can read or overwrite individual GPRs, e.g. for difftest register restore.
- Exports the full register contents as one flat bus for the DPI register-read block; this block is the write direction of that sim-to-GPR interface.

Parameters:
- XLEN, 64, register width in bits
- TIMEOUT, 255, maximum cycles a debug access may wait for a free write slot before erroring (range 1..1023)

Ports:
- clock  input  1  sole clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- raddr1  input  5  core read port 1 address
- rdata1  output  XLEN  core read data 1 (combinational)
- raddr2  input  5  core read port 2 address
- rdata2  output  XLEN  core read data 2 (combinational)
- wen  input  1  core write-back enable
- waddr  input  5  core write-back address
- wdata  input  XLEN  core write-back data
- halted  input  1  core halted; debug may access even if wen=1
- dbg_req_valid  input  1  debug request valid
- dbg_req_ready  output  1  debug request accepted when valid&ready
- dbg_req_write  input  1  1=write, 0=read
- dbg_req_addr  input  5  target GPR index
- dbg_req_wdata  input  XLEN  debug write data
- dbg_resp_valid  output  1  response valid
- dbg_resp_ready  input  1  response consumed when valid&ready
- dbg_resp_rdata  output  XLEN  read data (0 for writes/errors)
- dbg_resp_err  output  1  1=timed out, no access performed
- rf_flat  output  32*XLEN  register i on bits [i*XLEN +: XLEN]; bits [XLEN-1:0] always 0

Behaviour:
- Reset: all 32 registers cleared to 0, FSM to IDLE, wait counter 0.
- Reset: dbg_resp_valid=0, dbg_resp_rdata=0, dbg_resp_err=0.
- Reset mid-operation aborts the access with no register update and no response.
- x0 is hardwired: reads return 0, and writes from the core or debug port are discarded.
- Core reads are combinational from stored state, with no write-to-read bypass: a read in the same cycle as a write to that register returns the old value.
- Core write: if wen=1 and waddr!=0, the register is updated at the edge.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - dbg_req_ready=1.
  - On valid&ready, latch write, addr and wdata, clear the counter, and go to WAIT.
- WAIT:
  - dbg_req_ready=0.
  - A slot is free when halted=1 or wen=0.
  - If the slot is free this cycle:
    - Read: capture reg[addr] (0 for x0) into resp_rdata.
    - Write: write latched data at this edge (discarded for x0), resp_rdata=0.
    - err=0; go to RESP.
  - Core/debug write collision while halted=1: the debug write wins and the core write for that cycle is dropped (the core is halted, so wen is not expected).
  - If the slot is not free: increment the counter.
  - When the counter reaches TIMEOUT with no free slot: rdata=0, err=1, no access performed; go to RESP.
- RESP:
  - dbg_resp_valid=1 with rdata and err held stable until dbg_resp_ready=1.
  - Then go to IDLE, and clear dbg_resp_valid at that edge.
  - dbg_req_ready stays 0 in RESP, so the next request is accepted no earlier than the cycle after the handshake.
- Latency with a free slot: accept at edge N, access at edge N+1, dbg_resp_valid high from cycle N+1 onward.
- rf_flat reflects registered state; a write becomes visible on the cycle after its edge.

Test Plan:
- Reset, then read all GPRs via debug and rf_flat -> all 0, err=0, one response per request.
- Core writes x5=0x1234_5678_9ABC_DEF0, then debug reads x5 with wen=0 -> rdata=0x123456789ABCDEF0, resp_valid one cycle after accept.
- Debug writes x0=0xFFFF… then core reads raddr1=0 -> rdata1=0, rf_flat[63:0]=0, err=0.
- Debug write x10=0xAA with halted=0 and wen=1 for 3 cycles, then wen=0 -> write lands on the 4th WAIT cycle, x10=0xAA, err=0.
- TIMEOUT=4, halted=0, wen held 1 -> resp_err=1, rdata=0, target register unchanged.
- Hold dbg_resp_ready=0 for 5 cycles in RESP -> valid/rdata stable, ready=0.
- Assert reset in WAIT -> no response, FSM IDLE, all regs 0.
